// File: rtl/mpa_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
package mpa_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

endpackage

// File: rtl/RCA.sv
// WIDTH-bit ripple-carry adder: S = A + B + Ci, Co = carry out of the MSB.
module RCA #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic [WIDTH-1:0] S,
  output logic             Co
);

  logic [WIDTH:0] c;

  // Bit-serial carry propagation, one full adder per bit.
  always_comb begin
    c    = '0;
    S    = '0;
    c[0] = Ci;
    for (int i = 0; i < WIDTH; i++) begin
      S[i]   = A[i] ^ B[i] ^ c[i];
      c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
  end

  assign Co = c[WIDTH];

endmodule

// File: rtl/mpa_seq.sv
// Multi-precision add/subtract sequencer: one WIDTH-bit adder walks an
// operation of (cmd_len+1) words, LS word first, carrying between words.
module mpa_seq
  import mpa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_vld,
  output logic             cmd_rdy,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic             cmd_sub,
  input  logic             cmd_ci,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_S,
  output logic             out_lst,
  output logic             out_Co,
  output logic             out_Ov,
  output logic             busy
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len;
  logic             sub;
  logic             c;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             cmd_xfer;
  logic             in_xfer;
  logic             out_xfer;
  logic             last_word;

  // Subtraction is A + ~B + C; the caller supplies C=1 for a plain A-B.
  assign b_eff = in_B ^ {WIDTH{sub}};

  RCA #(.WIDTH(WIDTH)) u_rca (
    .A  (in_A),
    .B  (b_eff),
    .Ci (c),
    .S  (sum),
    .Co (co)
  );

  assign cmd_rdy   = (state == IDLE);
  assign busy      = (state == RUN);
  // Single output register: accept a new pair whenever it is empty or draining.
  assign in_rdy    = (state == RUN) && (!out_vld || out_rdy);
  assign cmd_xfer  = cmd_vld && cmd_rdy;
  assign in_xfer   = in_vld && in_rdy;
  assign out_xfer  = out_vld && out_rdy;
  // cnt is compared before incrementing, so len = 2^CNT_W-1 ends cleanly.
  assign last_word = (cnt == len);

  // Control FSM, word counter, inter-word carry and the output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      len     <= '0;
      sub     <= ADD;
      c       <= 1'b0;
      out_vld <= 1'b0;
      out_S   <= '0;
      out_lst <= 1'b0;
      out_Co  <= 1'b0;
      out_Ov  <= 1'b0;
    end else begin
      // An in transfer below overrides this and keeps the register full.
      if (out_xfer) begin
        out_vld <= 1'b0;
      end
      case (state)
        IDLE: begin
          // A held final word in out_* is left alone; only C is reloaded.
          if (cmd_xfer) begin
            len   <= cmd_len;
            sub   <= cmd_sub;
            c     <= cmd_ci;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (in_xfer) begin
            out_S   <= sum;
            out_Co  <= co;
            c       <= co;
            // Carry into MSB xor carry out of MSB.
            out_Ov  <= in_A[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1] ^ co;
            out_lst <= last_word;
            out_vld <= 1'b1;
            cnt     <= cnt + 1'b1;
            if (last_word) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpa_seq.sv
// Directed bench for mpa_seq with an expected-result queue.
module tb_mpa_seq;
  import mpa_pkg::*;

  localparam int WIDTH = 32;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_vld = 1'b0;
  logic             cmd_rdy;
  logic [CNT_W-1:0] cmd_len = '0;
  logic             cmd_sub = 1'b0;
  logic             cmd_ci = 1'b0;
  logic             in_vld = 1'b0;
  logic             in_rdy;
  logic [WIDTH-1:0] in_A = '0;
  logic [WIDTH-1:0] in_B = '0;
  logic             out_vld;
  logic             out_rdy = 1'b1;
  logic [WIDTH-1:0] out_S;
  logic             out_lst;
  logic             out_Co;
  logic             out_Ov;
  logic             busy;

  mpa_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cmd_vld (cmd_vld),
    .cmd_rdy (cmd_rdy),
    .cmd_len (cmd_len),
    .cmd_sub (cmd_sub),
    .cmd_ci  (cmd_ci),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .in_A    (in_A),
    .in_B    (in_B),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_S   (out_S),
    .out_lst (out_lst),
    .out_Co  (out_Co),
    .out_Ov  (out_Ov),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             co;
    logic             lst;
    logic             ov;
  } exp_t;

  exp_t sb[$];
  exp_t pe;

  int   checks = 0;
  int   failures = 0;

  // Reference model state for the operation in progress.
  logic m_c = 1'b0;
  logic m_sub = 1'b0;
  int   m_idx = 0;
  int   m_len = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop and compare on every output transfer (sampled mid-cycle).
  always @(negedge clk) begin
    if (rst_n && out_vld && out_rdy) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 64'(out_S), 64'hDEAD_0000_0000);
      end else begin
        pe = sb.pop_front();
        chk("out_S",   64'(out_S),   64'(pe.s));
        chk("out_Co",  64'(out_Co),  64'(pe.co));
        chk("out_lst", 64'(out_lst), 64'(pe.lst));
        chk("out_Ov",  64'(out_Ov),  64'(pe.ov));
      end
    end
  end

  task automatic do_cmd(input int len, input logic sub, input logic ci);
    int n;
    n       = 0;
    cmd_len = CNT_W'(len);
    cmd_sub = sub;
    cmd_ci  = ci;
    cmd_vld = 1'b1;
    @(negedge clk);
    while (!cmd_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_rdy) begin
      chk("cmd_rdy_timeout", 64'(cmd_rdy), 64'(1));
    end else begin
      m_len = len;
      m_sub = sub;
      m_c   = ci;
      m_idx = 0;
    end
    @(posedge clk);
    #1;
    cmd_vld = 1'b0;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] bb;
    exp_t             e;
    int               n;
    bb    = m_sub ? ~b : b;
    r     = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, m_c};
    e.s   = r[WIDTH-1:0];
    e.co  = r[WIDTH];
    e.lst = (m_idx == m_len);
    e.ov  = (a[WIDTH-1] == bb[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    in_A   = a;
    in_B   = b;
    in_vld = 1'b1;
    n      = 0;
    @(negedge clk);
    while (!in_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_rdy) begin
      chk("in_rdy_timeout", 64'(in_rdy), 64'(1));
    end else begin
      sb.push_back(e);
      m_c = e.co;
      m_idx++;
    end
    @(posedge clk);
    #1;
    in_vld = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] held;
    int               start;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_vld", 64'(out_vld), 64'(0));
    chk("rst_busy",    64'(busy),    64'(0));
    chk("rst_cmd_rdy", 64'(cmd_rdy), 64'(1));
    chk("rst_in_rdy",  64'(in_rdy),  64'(0));
    chk("rst_out_S",   64'(out_S),   64'(0));
    chk("rst_flags",   64'({out_lst, out_Co, out_Ov}), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word with carry out, one-cycle latency
    do_cmd(0, ADD, 1'b0);
    chk("t1_busy", 64'(busy), 64'(1));
    send_word(32'hFFFF_FFFF, 32'h0000_0001);
    chk("t1_latency_vld", 64'(out_vld), 64'(1));
    wait_drain();

    // Carry chain across three words
    do_cmd(2, ADD, 1'b0);
    send_word(32'hFFFF_FFFF, 32'h0000_0001);
    send_word(32'hFFFF_FFFF, 32'h0000_0000);
    send_word(32'h0000_0000, 32'h0000_0000);
    wait_drain();
    chk("t2_idle", 64'(busy), 64'(0));

    // Subtract, then swapped operands (borrow)
    do_cmd(1, SUB, 1'b1);
    send_word(32'h0000_0000, 32'h0000_0001);
    send_word(32'h0000_0001, 32'h0000_0000);
    wait_drain();
    do_cmd(1, SUB, 1'b1);
    send_word(32'h0000_0001, 32'h0000_0000);
    send_word(32'h0000_0000, 32'h0000_0001);
    wait_drain();

    // Backpressure on a 4-word operation
    do_cmd(3, ADD, 1'b0);
    out_rdy = 1'b0;
    send_word($urandom, $urandom);
    held = out_S;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_hold_in_rdy", 64'(in_rdy),  64'(0));
      chk("t4_hold_vld",    64'(out_vld), 64'(1));
      chk("t4_hold_S",      64'(out_S),   64'(held));
      chk("t4_hold_lst",    64'(out_lst), 64'(0));
    end
    @(posedge clk);
    #1;
    out_rdy = 1'b1;
    start = cyc;
    send_word($urandom, $urandom);
    send_word($urandom, $urandom);
    send_word(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("t4_throughput", 64'(cyc - start), 64'(3));
    wait_drain();

    // Reset in the middle of an operation that has a live carry
    do_cmd(3, ADD, 1'b0);
    send_word(32'hFFFF_FFFF, 32'h0000_0001);
    send_word(32'hFFFF_FFFF, 32'h0000_0000);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    chk("t5_out_vld", 64'(out_vld), 64'(0));
    chk("t5_busy",    64'(busy),    64'(0));
    chk("t5_cmd_rdy", 64'(cmd_rdy), 64'(1));
    do_cmd(0, ADD, 1'b0);
    send_word(32'h0000_0005, 32'h0000_0003);
    wait_drain();

    // Signed overflow; next command accepted while last word is still held
    do_cmd(0, ADD, 1'b0);
    out_rdy = 1'b0;
    send_word(32'h7FFF_FFFF, 32'h0000_0001);
    do_cmd(0, ADD, 1'b0);
    chk("t6_pending_vld", 64'(out_vld), 64'(1));
    chk("t6_pending_S",   64'(out_S),   64'(32'h8000_0000));
    chk("t6_busy",        64'(busy),    64'(1));
    out_rdy = 1'b1;
    send_word(32'hFFFF_FFFF, 32'h0000_0001);
    wait_drain();

    // Maximum-length operation, 2^CNT_W words
    do_cmd((1 << CNT_W) - 1, ADD, 1'b1);
    for (int i = 0; i < (1 << CNT_W); i++) begin
      send_word($urandom, $urandom);
    end
    wait_drain();
    chk("t7_idle", 64'(busy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mpa_seq.md
Name: mpa_seq

Overview:
- Multi-precision add/subtract sequencer around one WIDTH-bit ripple-carry adder (RCA).
- Accepts a command carrying word count, mode and initial carry, then consumes operand word pairs least-significant first.
- Carries between words in a register and emits one registered sum word per input pair.
- Sits between a bignum/crypto operand streamer and its result sink; lets one narrow adder serve arbitrarily wide operations.

Parameters:
- WIDTH, 32, adder word width in bits.
- CNT_W, 8, width of word-count field; max operation length 2^CNT_W words.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- cmd_vld  input  1  command valid.
- cmd_rdy  output  1  command ready.
- cmd_len  input  CNT_W  number of words minus 1.
- cmd_sub  input  1  1 = subtract (B inverted), 0 = add.
- cmd_ci  input  1  initial carry into word 0.
- in_vld  input  1  operand pair valid.
- in_rdy  output  1  operand pair ready.
- in_A  input  WIDTH  operand A word.
- in_B  input  WIDTH  operand B word.
- out_vld  output  1  sum word valid.
- out_rdy  input  1  sink ready.
- out_S  output  WIDTH  sum word.
- out_lst  output  1  marks final word of the operation.
- out_Co  output  1  carry out of this word; final carry/not-borrow when out_lst.
- out_Ov  output  1  signed overflow of this word's MSB; meaningful when out_lst.
- busy  output  1  state is RUN.

Behaviour:
- Handshake rule: a transfer occurs on a cycle where vld & rdy at the rising clk edge.
- Producers hold vld and data stable until the transfer; the block likewise holds out_* stable while out_vld & !out_rdy.
- Reset (rst_n=0 at clk edge), including mid-operation:
  - state=IDLE; cnt=0; carry reg C=0; out_vld=0; out_S=0; out_lst=0; out_Co=0; out_Ov=0.
  - Any in-flight operation is discarded; no partial output completes.
- States IDLE and RUN.
- IDLE:
  - cmd_rdy=1, in_rdy=0, busy=0.
  - On cmd transfer: latch len=cmd_len, sub=cmd_sub, C=cmd_ci, cnt=0; go to RUN.
  - in_vld is ignored in IDLE.
- RUN:
  - cmd_rdy=0, busy=1.
  - in_rdy = !out_vld | out_rdy (single output register, full throughput).
- On in transfer:
  - Adder computes in_A + (in_B ^ {WIDTH{sub}}) + C.
  - out_S <= sum; out_Co <= adder Co; C <= adder Co; out_vld <= 1.
  - out_Ov <= A'[msb] ^ B'[msb] ^ S[msb] ^ Co, i.e. carry into MSB xor carry out, where B' is the possibly inverted B.
  - out_lst <= (cnt==len); cnt <= cnt+1.
  - If cnt==len, return to IDLE.
- Out transfer without a simultaneous in transfer: out_vld <= 0.
- Simultaneous out and in transfer: the register reloads and out_vld stays 1.
- Latency: 1 cycle from in transfer to out_vld.
- Subtraction convention: A−B uses cmd_sub=1, cmd_ci=1; final out_Co=1 means no borrow. Borrow-in chaining uses cmd_ci=0.
- Boundary cases:
  - len=0 is a single-word operation; out_lst=1 on the first output.
  - len=2^CNT_W−1: cnt compares equal before it wraps, so there is no wrap ambiguity.
  - A command may be accepted in IDLE while the previous last word is still held in out_*. C is reloaded; the pending output is unaffected.
- Arithmetic: all WIDTH-bit, unsigned modulo 2^WIDTH per word; carry is 1 bit.

Decomposition:
- Package mpa_pkg holds:
  - state typedef: enum logic {IDLE, RUN}.
  - mode constants ADD=1'b0, SUB=1'b1.
- Sub-module: instantiate the existing RCA #(.WIDTH(WIDTH)) as the combinational datapath. Its Ci is driven by C; its B is driven by in_B ^ {WIDTH{sub}}.
- FSM, counter, carry register and output register stay in mpa_seq.

Test Plan:
1. Single word: len=0, add, ci=0, A=FFFFFFFF, B=00000001 -> one output S=00000000, Co=1, lst=1, 1 cycle after transfer.
2. Carry chain: len=2, A={FFFFFFFF,FFFFFFFF,00000000}, B={00000001,0,0} (LS first) -> S={0,0,00000001}, Co of last=0, lst only on 3rd word.
3. Subtract: len=1, sub=1, ci=1, A={00000000,00000001}, B={00000001,00000000} -> S={FFFFFFFF,00000000}, final Co=1 (no borrow). Swapped operands -> S={00000001,FFFFFFFF}, Co=0.
4. Backpressure: during a 4-word op hold out_rdy=0 for 3 cycles -> out_S/out_lst stable, in_rdy=0. On release, full throughput of 1 word/cycle resumes and words are in order.
5. Reset mid-op: assert rst_n=0 after 2 of 4 words -> next cycle out_vld=0, busy=0, cmd_rdy=1. A new len=0 command then produces a correct result with no stale carry.
6. Overflow: len=0, add, A=7FFFFFFF, B=00000001 -> S=80000000, Ov=1, Co=0. A=FFFFFFFF, B=00000001 -> Ov=0, Co=1.
